// File: rtl/stack_if.sv
// Processor-to-stack bus: push/pop strobes with data in, top-of-stack and status back.
interface stack_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic [AW:0]      high_water;
    logic             overflow_err;
    logic             underflow_err;

    modport master (
        output push, pop, data_in,
        input  data_out, full, empty, count, high_water, overflow_err, underflow_err
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, full, empty, count, high_water, overflow_err, underflow_err
    );
endinterface

// File: rtl/stack_unit.sv
// LIFO stack for the processor: one push/pop/replace per cycle, top-of-stack
// presented from registered state, high-water mark and sticky error flags.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic   clk,
    input  logic   resetN,
    stack_if.slave bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      sp;
    logic [AW:0]      sp_nxt;
    logic [AW:0]      sp_m1;
    logic [AW:0]      high_water;
    logic             overflow_err;
    logic             underflow_err;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             set_ovf;
    logic             set_udf;
    logic             is_empty;
    logic             is_full;

    assign sp_m1    = sp - 1'b1;
    assign is_empty = (sp == '0);
    assign is_full  = (sp == DEPTH_C);

    always_comb begin
        sp_nxt  = sp;
        wr_en   = 1'b0;
        wr_addr = sp[AW-1:0];
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (bus.push && bus.pop) begin
            if (!is_empty) begin
                // replace top in place; also legal when full
                wr_en   = 1'b1;
                wr_addr = sp_m1[AW-1:0];
            end else begin
                wr_en   = 1'b1;
                wr_addr = '0;
                sp_nxt  = (AW+1)'(1);
                set_udf = 1'b1;
            end
        end else if (bus.push) begin
            if (!is_full) begin
                wr_en  = 1'b1;
                sp_nxt = sp + 1'b1;
            end else begin
                set_ovf = 1'b1;
            end
        end else if (bus.pop) begin
            if (!is_empty) begin
                sp_nxt = sp_m1;
            end else begin
                set_udf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            sp            <= '0;
            high_water    <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            sp            <= sp_nxt;
            high_water    <= (sp_nxt > high_water) ? sp_nxt : high_water;
            overflow_err  <= overflow_err | set_ovf;
            underflow_err <= underflow_err | set_udf;
        end
    end

    // storage is not cleared by reset, but strobes in the reset cycle must not write
    always_ff @(posedge clk) begin
        if (resetN && wr_en) begin
            mem[wr_addr] <= bus.data_in;
        end
    end

    assign bus.data_out      = is_empty ? '0 : mem[sp_m1[AW-1:0]];
    assign bus.full          = is_full;
    assign bus.empty         = is_empty;
    assign bus.count         = sp;
    assign bus.high_water    = high_water;
    assign bus.overflow_err  = overflow_err;
    assign bus.underflow_err = underflow_err;
endmodule

// File: tb/tb_stack_unit.sv
// Randomized and directed bench for stack_unit against a queue-based LIFO model.
module tb_stack_unit;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk;
    logic resetN;

    stack_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    int         m_hw;
    bit         m_ovf;
    bit         m_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_top();
        return (q.size() == 0) ? 8'h00 : q[$];
    endfunction

    task automatic check_all();
        check("count", 32'(bus.count), 32'(q.size()));
        check("empty", 32'(bus.empty), 32'(q.size() == 0));
        check("full", 32'(bus.full), 32'(q.size() == DEPTH));
        check("data_out", 32'(bus.data_out), 32'(model_top()));
        check("high_water", 32'(bus.high_water), 32'(m_hw));
        check("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
        check("underflow_err", 32'(bus.underflow_err), 32'(m_udf));
    endtask

    task automatic model_update(input bit p, input bit o, input logic [7:0] d);
        if (p && o) begin
            if (q.size() != 0) q[q.size()-1] = d;
            else begin
                q.push_back(d);
                m_udf = 1'b1;
            end
        end else if (p) begin
            if (q.size() < DEPTH) q.push_back(d);
            else m_ovf = 1'b1;
        end else if (o) begin
            if (q.size() != 0) void'(q.pop_back());
            else m_udf = 1'b1;
        end
        if (q.size() > m_hw) m_hw = q.size();
    endtask

    // one clocked operation; data_out is checked in the strobe cycle and after the edge
    task automatic step(input bit p, input bit o, input logic [7:0] d);
        @(negedge clk);
        resetN      = 1'b1;
        bus.push    = p;
        bus.pop     = o;
        bus.data_in = d;
        #1;
        check("dout_in_cycle", 32'(bus.data_out), 32'(model_top()));
        @(posedge clk);
        model_update(p, o, d);
        #1;
        check_all();
    endtask

    task automatic do_reset(input bit p, input logic [7:0] d);
        @(negedge clk);
        resetN      = 1'b0;
        bus.push    = p;
        bus.pop     = 1'b0;
        bus.data_in = d;
        @(posedge clk);
        q.delete();
        m_hw  = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        resetN      = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        m_hw  = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        repeat (2) @(posedge clk);
        do_reset(1'b0, 8'h00);

        // three pushes then three pops
        step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33);
        check("plan_count3", 32'(bus.count), 32'd3);
        check("plan_top33", 32'(bus.data_out), 32'h33);
        check("plan_hw3", 32'(bus.high_water), 32'd3);
        step(0, 1, 8'h00); step(0, 1, 8'h00); step(0, 1, 8'h00);
        check("plan_empty", 32'(bus.empty), 32'd1);

        // fill, then overflow
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i));
        check("plan_full", 32'(bus.full), 32'd1);
        check("plan_top0f", 32'(bus.data_out), 32'h0F);
        step(1, 0, 8'hAA);
        check("plan_ovf", 32'(bus.overflow_err), 32'd1);
        check("plan_ovf_top", 32'(bus.data_out), 32'h0F);
        // replace while full: no overflow growth, count stays 16
        step(1, 1, 8'h99);
        check("plan_repl_full_cnt", 32'(bus.count), 32'd16);

        // underflow cases
        do_reset(1'b0, 8'h00);
        step(0, 1, 8'h00);
        check("plan_udf", 32'(bus.underflow_err), 32'd1);
        step(1, 1, 8'h5A);
        check("plan_pp_empty_top", 32'(bus.data_out), 32'h5A);
        check("plan_pp_empty_cnt", 32'(bus.count), 32'd1);

        // ADD operand fetch
        do_reset(1'b0, 8'h00);
        step(1, 0, 8'h07); step(1, 0, 8'h03);
        step(0, 1, 8'h00); step(0, 1, 8'h00);
        check("plan_add_cnt", 32'(bus.count), 32'd0);

        // replace with count 2
        step(1, 0, 8'h10); step(1, 0, 8'h44);
        step(1, 1, 8'h99);
        check("plan_repl_top", 32'(bus.data_out), 32'h99);
        check("plan_repl_udf", 32'(bus.underflow_err), 32'd0);

        // reset with push strobe after five pushes
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i));
        do_reset(1'b1, 8'hEE);
        check("plan_rst_dout", 32'(bus.data_out), 32'd0);

        // randomized phases biased towards filling or draining
        for (int i = 0; i < 3000; i++) begin
            bit         up;
            bit         p;
            bit         o;
            logic [7:0] d;
            up = ((i / 150) % 2) == 0;
            p  = ($urandom_range(0, 99) < (up ? 70 : 30));
            o  = ($urandom_range(0, 99) < (up ? 30 : 70));
            d  = 8'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset(p, d);
            else step(p, o, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
